// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the direct-mapped instruction cache:
//   ICACHE_NSETS / ICACHE_IDX_W / ICACHE_TAG_W : geometry of the frame array
//   icachef_t      : byte-address view {tag, idx, bytoff}
//   icache_frame_t : one stored frame {valid, tag, data}
//   icache_state_t : fill FSM states {IDLE, FETCH}
//   word_align()   : clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package cpu_types_pkg;

    localparam int ICACHE_NSETS = 16;
    localparam int ICACHE_IDX_W = $clog2(ICACHE_NSETS);
    localparam int ICACHE_TAG_W = 32 - ICACHE_IDX_W - 2;

    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icachef_t;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        logic [31:0]             data;
    } icache_frame_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

    // Memory control only takes word addresses.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/icache_dm_if.sv
// -----------------------------------------------------------------------------
// icache_dm_if
// Bundles the datapath-side and memory-control-side signals of the icache.
//   Datapath side : imemREN, imemaddr, iflush (requests)  -> ihit, imemload
//   Memory side   : iwait, iload (responses)              <- iREN, iaddr
// modport slave  : the cache
// modport master : the environment driving requests and memory responses
// -----------------------------------------------------------------------------
interface icache_dm_if;

    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iflush;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    modport slave (
        input  imemREN, imemaddr, iflush, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, iflush, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );

endinterface

// File: rtl/icache_dm.sv
// -----------------------------------------------------------------------------
// icache_dm
// Direct-mapped, one-word-per-frame instruction cache between the datapath
// instruction port and memory control. Hits answer combinationally while the
// FSM is IDLE; a miss moves to FETCH and holds iREN/iaddr until memory drops
// iwait, at which point the frame is installed and the FSM returns to IDLE
// for a fresh lookup.
// Ports:
//   CLK  : clock, all state on posedge
//   nRST : synchronous active-low reset
//   bus  : icache_dm_if.slave (imemREN/imemaddr/iflush/iwait/iload in,
//          ihit/imemload/iREN/iaddr out)
// -----------------------------------------------------------------------------
module icache_dm
    import cpu_types_pkg::*;
(
    input  logic       CLK,
    input  logic       nRST,
    icache_dm_if.slave bus
);

    icache_frame_t frames_q [ICACHE_NSETS];
    icache_state_t state_q;
    logic [31:0]   miss_addr_q;
    logic          iren_q;
    logic [31:0]   iaddr_q;

    icachef_t      req_view_s;
    icachef_t      fill_view_s;
    icache_frame_t lookup_frame_s;
    logic          hit_s;
    logic          fill_we_s;
    logic          unused_bytoff_s;

    assign req_view_s  = bus.imemaddr;
    assign fill_view_s = miss_addr_q;

    // Byte offsets never select anything in a word-per-frame cache.
    assign unused_bytoff_s = ^{req_view_s.bytoff, fill_view_s.bytoff};

    // The fill lands on the cycle memory stops waiting while we are fetching.
    assign fill_we_s = (state_q == FETCH) && !bus.iwait;

    // Tag compare against the indexed frame; only meaningful in IDLE.
    always_comb begin
        lookup_frame_s = frames_q[req_view_s.idx];
        hit_s          = 1'b0;
        if (state_q == IDLE) begin
            hit_s = bus.imemREN && lookup_frame_s.valid &&
                    (lookup_frame_s.tag == req_view_s.tag);
        end else begin
            hit_s = 1'b0;
        end
    end

    assign bus.ihit     = hit_s;
    assign bus.imemload = hit_s ? lookup_frame_s.data : 32'h0000_0000;
    assign bus.iREN     = iren_q;
    assign bus.iaddr    = iaddr_q;

    // Frame array: fill writes first, flush afterwards so a coincident flush wins.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < ICACHE_NSETS; i++) begin
                frames_q[i].valid <= 1'b0;
            end
        end else begin
            if (fill_we_s) begin
                frames_q[fill_view_s.idx] <= '{valid: 1'b1,
                                               tag:   fill_view_s.tag,
                                               data:  bus.iload};
            end
            if (bus.iflush) begin
                for (int i = 0; i < ICACHE_NSETS; i++) begin
                    frames_q[i].valid <= 1'b0;
                end
            end
        end
    end

    // Fill FSM with registered memory-request outputs.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q     <= IDLE;
            miss_addr_q <= 32'h0000_0000;
            iren_q      <= 1'b0;
            iaddr_q     <= 32'h0000_0000;
        end else begin
            case (state_q)
                IDLE: begin
                    // A flush in the same cycle suppresses the miss; the
                    // request is simply re-examined next cycle.
                    if (bus.imemREN && !hit_s && !bus.iflush) begin
                        state_q     <= FETCH;
                        miss_addr_q <= word_align(bus.imemaddr);
                        iren_q      <= 1'b1;
                        iaddr_q     <= word_align(bus.imemaddr);
                    end else begin
                        state_q <= IDLE;
                        iren_q  <= 1'b0;
                        iaddr_q <= 32'h0000_0000;
                    end
                end
                FETCH: begin
                    // Requests are never abandoned: address changes on the
                    // datapath side are ignored until the fill returns.
                    if (!bus.iwait) begin
                        state_q <= IDLE;
                        iren_q  <= 1'b0;
                        iaddr_q <= 32'h0000_0000;
                    end else begin
                        state_q <= FETCH;
                        iren_q  <= 1'b1;
                        iaddr_q <= miss_addr_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    iren_q  <= 1'b0;
                    iaddr_q <= 32'h0000_0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
module tb_icache_dm;

    logic clk;
    logic nrst;
    int   total_cnt;
    int   pass_cnt;

    icache_dm_if bus ();

    icache_dm dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        bus.imemREN = 1'b0; bus.imemaddr = 32'h0; bus.iflush = 1'b0;
        bus.iwait = 1'b1; bus.iload = 32'h0;
        tick(); tick();
        nrst = 1'b1;
        #1;
        total_cnt++; if (bus.ihit !== 1'b0) $display("FAIL reset_ihit: got %b want 0", bus.ihit); else pass_cnt++;
        total_cnt++; if (bus.iREN !== 1'b0) $display("FAIL reset_iREN: got %b want 0", bus.iREN); else pass_cnt++;
        total_cnt++; if (bus.iaddr !== 32'h0) $display("FAIL reset_iaddr: got %h want 0", bus.iaddr); else pass_cnt++;
        total_cnt++; if (bus.imemload !== 32'h0) $display("FAIL reset_imemload: got %h want 0", bus.imemload); else pass_cnt++;
    endtask

    task automatic test_first_miss();
        bus.imemREN = 1'b1; bus.imemaddr = 32'h0000_0040; bus.iwait = 1'b1;
        #1;
        total_cnt++; if (bus.ihit !== 1'b0) $display("FAIL miss1_ihit: got %b want 0", bus.ihit); else pass_cnt++;
        tick();
        total_cnt++; if (bus.iaddr !== 32'h40) $display("FAIL miss1_iaddr: got %h want 00000040", bus.iaddr); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            total_cnt++; if (bus.iREN !== 1'b1 || bus.ihit !== 1'b0) $display("FAIL miss1_wait%0d: got iREN=%b ihit=%b want 1/0", i, bus.iREN, bus.ihit); else pass_cnt++;
            tick();
        end
        bus.iwait = 1'b0; bus.iload = 32'h2001_0005;
        tick();
        bus.iwait = 1'b1;
        #1;
        total_cnt++; if (bus.ihit !== 1'b1) $display("FAIL miss1_hit: got %b want 1", bus.ihit); else pass_cnt++;
        total_cnt++; if (bus.imemload !== 32'h2001_0005) $display("FAIL miss1_data: got %h want 20010005", bus.imemload); else pass_cnt++;
        total_cnt++; if (bus.iREN !== 1'b0) $display("FAIL miss1_iREN_after: got %b want 0", bus.iREN); else pass_cnt++;
    endtask

    task automatic test_conflict();
        tick();
        total_cnt++; if (bus.ihit !== 1'b1 || bus.iREN !== 1'b0) $display("FAIL rehit: got ihit=%b iREN=%b want 1/0", bus.ihit, bus.iREN); else pass_cnt++;
        bus.imemaddr = 32'h0000_0080;
        #1;
        total_cnt++; if (bus.ihit !== 1'b0) $display("FAIL conf_miss: got %b want 0", bus.ihit); else pass_cnt++;
        tick();
        total_cnt++; if (bus.iREN !== 1'b1 || bus.iaddr !== 32'h80) $display("FAIL conf_req: got iREN=%b iaddr=%h want 1/00000080", bus.iREN, bus.iaddr); else pass_cnt++;
        bus.iwait = 1'b0; bus.iload = 32'hDEAD_BEEF;
        tick();
        bus.iwait = 1'b1;
        #1;
        total_cnt++; if (bus.ihit !== 1'b1 || bus.imemload !== 32'hDEAD_BEEF) $display("FAIL conf_fill: got ihit=%b data=%h want 1/deadbeef", bus.ihit, bus.imemload); else pass_cnt++;
        bus.imemaddr = 32'h0000_0040;
        #1;
        total_cnt++; if (bus.ihit !== 1'b0 || bus.imemload !== 32'h0) $display("FAIL conf_evict: got ihit=%b data=%h want 0/0", bus.ihit, bus.imemload); else pass_cnt++;
        bus.imemREN = 1'b0;
        #1;
    endtask

    task automatic test_addr_change();
        bus.imemREN = 1'b1; bus.imemaddr = 32'h0000_0044;
        tick();
        bus.imemaddr = 32'h0000_0100;
        tick();
        total_cnt++; if (bus.iaddr !== 32'h44 || bus.iREN !== 1'b1 || bus.ihit !== 1'b0) $display("FAIL chg_hold: got iaddr=%h iREN=%b ihit=%b want 00000044/1/0", bus.iaddr, bus.iREN, bus.ihit); else pass_cnt++;
        bus.iwait = 1'b0; bus.iload = 32'h1111_2222;
        tick();
        bus.iwait = 1'b1;
        #1;
        total_cnt++; if (bus.ihit !== 1'b0 || bus.iREN !== 1'b0) $display("FAIL chg_newmiss: got ihit=%b iREN=%b want 0/0", bus.ihit, bus.iREN); else pass_cnt++;
        tick();
        total_cnt++; if (bus.iaddr !== 32'h100 || bus.iREN !== 1'b1) $display("FAIL chg_req: got iaddr=%h iREN=%b want 00000100/1", bus.iaddr, bus.iREN); else pass_cnt++;
        bus.iwait = 1'b0; bus.iload = 32'h3333_4444;
        tick();
        bus.iwait = 1'b1;
        #1;
        total_cnt++; if (bus.imemload !== 32'h3333_4444) $display("FAIL chg_fill100: got %h want 33334444", bus.imemload); else pass_cnt++;
        bus.imemaddr = 32'h0000_0044;
        #1;
        total_cnt++; if (bus.ihit !== 1'b1 || bus.imemload !== 32'h1111_2222) $display("FAIL chg_hit44: got ihit=%b data=%h want 1/11112222", bus.ihit, bus.imemload); else pass_cnt++;
    endtask

    task automatic test_flush();
        bus.imemaddr = 32'h0000_0040;
        tick();
        bus.iwait = 1'b0; bus.iload = 32'h5555_5555;
        tick();
        bus.iwait = 1'b1;
        #1;
        total_cnt++; if (bus.ihit !== 1'b1) $display("FAIL fl_prefill: got %b want 1", bus.ihit); else pass_cnt++;
        bus.imemREN = 1'b0; bus.iflush = 1'b1;
        tick();
        bus.iflush = 1'b0; bus.imemREN = 1'b1;
        #1;
        total_cnt++; if (bus.ihit !== 1'b0) $display("FAIL fl_miss40: got %b want 0", bus.ihit); else pass_cnt++;
        bus.imemaddr = 32'h0000_0044;
        #1;
        total_cnt++; if (bus.ihit !== 1'b0) $display("FAIL fl_miss44: got %b want 0", bus.ihit); else pass_cnt++;
        // flush coincident with fill completion
        tick();
        bus.iwait = 1'b0; bus.iload = 32'h6666_6666; bus.iflush = 1'b1;
        tick();
        bus.iwait = 1'b1; bus.iflush = 1'b0;
        #1;
        total_cnt++; if (bus.ihit !== 1'b0 || bus.iREN !== 1'b0) $display("FAIL fl_coincide: got ihit=%b iREN=%b want 0/0", bus.ihit, bus.iREN); else pass_cnt++;
        // flush while waiting does not cancel the fill
        tick();
        bus.iflush = 1'b1;
        tick();
        bus.iflush = 1'b0;
        #1;
        total_cnt++; if (bus.iREN !== 1'b1 || bus.iaddr !== 32'h44) $display("FAIL fl_wait_keep: got iREN=%b iaddr=%h want 1/00000044", bus.iREN, bus.iaddr); else pass_cnt++;
        bus.iwait = 1'b0; bus.iload = 32'h7777_7777;
        tick();
        bus.iwait = 1'b1;
        #1;
        total_cnt++; if (bus.ihit !== 1'b1 || bus.imemload !== 32'h7777_7777) $display("FAIL fl_wait_fill: got ihit=%b data=%h want 1/77777777", bus.ihit, bus.imemload); else pass_cnt++;
    endtask

    task automatic test_reset_in_fetch();
        bus.imemaddr = 32'h0000_0048;
        tick();
        total_cnt++; if (bus.iREN !== 1'b1) $display("FAIL rf_enter: got iREN=%b want 1", bus.iREN); else pass_cnt++;
        nrst = 1'b0;
        tick();
        nrst = 1'b1; bus.imemREN = 1'b0;
        #1;
        total_cnt++; if (bus.iREN !== 1'b0 || bus.ihit !== 1'b0 || bus.iaddr !== 32'h0) $display("FAIL rf_abort: got iREN=%b ihit=%b iaddr=%h want 0/0/0", bus.iREN, bus.ihit, bus.iaddr); else pass_cnt++;
        bus.iwait = 1'b0; bus.iload = 32'h0BAD_0BAD;
        tick();
        bus.iwait = 1'b1; bus.imemREN = 1'b1;
        bus.imemaddr = 32'h0000_0048;
        #1;
        total_cnt++; if (bus.ihit !== 1'b0) $display("FAIL rf_late48: got %b want 0", bus.ihit); else pass_cnt++;
        bus.imemaddr = 32'h0000_0044;
        #1;
        total_cnt++; if (bus.ihit !== 1'b0) $display("FAIL rf_inval44: got %b want 0", bus.ihit); else pass_cnt++;
        bus.imemREN = 1'b0;
        #1;
    endtask

    task automatic test_unaligned();
        bus.imemREN = 1'b1; bus.imemaddr = 32'h0000_0043;
        #1;
        total_cnt++; if (bus.ihit !== 1'b0) $display("FAIL ua_miss: got %b want 0", bus.ihit); else pass_cnt++;
        tick();
        total_cnt++; if (bus.iaddr !== 32'h40) $display("FAIL ua_iaddr: got %h want 00000040", bus.iaddr); else pass_cnt++;
        bus.iwait = 1'b0; bus.iload = 32'h1234_5678;
        tick();
        bus.iwait = 1'b1;
        #1;
        total_cnt++; if (bus.ihit !== 1'b1 || bus.imemload !== 32'h1234_5678) $display("FAIL ua_hit43: got ihit=%b data=%h want 1/12345678", bus.ihit, bus.imemload); else pass_cnt++;
        bus.imemaddr = 32'h0000_0040;
        #1;
        total_cnt++; if (bus.ihit !== 1'b1) $display("FAIL ua_hit40: got %b want 1", bus.ihit); else pass_cnt++;
        bus.imemREN = 1'b0;
        #1;
        total_cnt++; if (bus.ihit !== 1'b0 || bus.imemload !== 32'h0) $display("FAIL ren_low: got ihit=%b data=%h want 0/0", bus.ihit, bus.imemload); else pass_cnt++;
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        test_reset();
        test_first_miss();
        test_conflict();
        test_addr_change();
        test_flush();
        test_reset_in_fetch();
        test_unaligned();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
